imm_extend_pipe: RTL

- Parametrised, pipelined immediate-extension unit for the MIPS datapath. Successor to the fixed 16->32 sign extender.
- Supports four extension modes: sign, zero, upper (LUI) and branch-offset (sign-extend then shift left 2).
- Results pass through a registered 2-entry skid buffer with valid/ready handshakes on both sides, plus a pass-through tag.
- Sits between decode and the ALU-operand / branch-target stages of the pipelined core.

---
 rtl/imm_ext_pkg.sv | 16 +
 rtl/imm_extend_pipe_if.sv | 30 +++
 rtl/imm_ext_core.sv | 28 ++
 rtl/imm_extend_pipe.sv | 79 +++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared mode encodings and width helpers for the immediate-extension units.
package imm_ext_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SIGN   = 2'b00;
  localparam mode_t MODE_ZERO   = 2'b01;
  localparam mode_t MODE_UPPER  = 2'b10;
  localparam mode_t MODE_BRANCH = 2'b11;

  // Branch mode shifts left by 2, so the result needs two spare bits above the immediate.
  function automatic bit legal_widths(int unsigned in_w, int unsigned out_w);
    return out_w >= in_w + 2;
  endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Upstream/downstream valid-ready bus of the immediate-extension pipe.
interface imm_extend_pipe_if
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  mode_t            in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign, zero, upper (LUI) and branch-offset modes.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_imm,
  input  mode_t            in_mode,
  output logic [OUT_W-1:0] result_c
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;

  always_comb begin
    sext     = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
    result_c = sext;
    case (in_mode)
      MODE_ZERO:   result_c = {{PAD_W{1'b0}}, in_imm};
      MODE_UPPER:  result_c = {in_imm, {PAD_W{1'b0}}};
      MODE_BRANCH: result_c = {sext[OUT_W-3:0], 2'b00};
      default:     result_c = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender followed by a registered 2-entry skid buffer with valid/ready on both sides.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  imm_extend_pipe_if.slave  bus,
  output logic [1:0]        occupancy
);

  if (!legal_widths(IN_W, OUT_W)) begin : g_bad_widths
    $fatal(1, "imm_extend_pipe: OUT_W must be at least IN_W+2");
  end

  logic [OUT_W-1:0] ext_c;
  logic [OUT_W-1:0] data0, data1;
  logic [TAG_W-1:0] tag0, tag1;
  logic             push, pop;

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .in_imm   (bus.in_imm),
    .in_mode  (bus.in_mode),
    .result_c (ext_c)
  );

  // Handshake flags depend only on flops (and reset), never on out_ready.
  assign bus.in_ready  = (occupancy != 2'd2) && !reset;
  assign bus.out_valid = (occupancy != 2'd0);
  assign bus.out_data  = data0;
  assign bus.out_tag   = tag0;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Entry 0 is always the head; entry 1 only fills while the head is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= 2'd0;
      data0     <= '0;
      tag0      <= '0;
      data1     <= '0;
      tag1      <= '0;
    end else begin
      case (occupancy)
        2'd0: begin
          if (push) begin
            data0     <= ext_c;
            tag0      <= bus.in_tag;
            occupancy <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            data0 <= ext_c;
            tag0  <= bus.in_tag;
          end else if (push) begin
            data1     <= ext_c;
            tag1      <= bus.in_tag;
            occupancy <= 2'd2;
          end else if (pop) begin
            occupancy <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            data0     <= data1;
            tag0      <= tag1;
            occupancy <= 2'd1;
          end
        end
        default: occupancy <= 2'd0;
      endcase
    end
  end

endmodule
